// File: rtl/harmonic_engine_pkg.sv
// rtl/harmonic_engine_pkg.sv - shared states, output gain shift and default parameters for harmonic_engine
package harmonic_engine_pkg;

    localparam int DEF_NUM_HARM = 64;
    localparam int DEF_PHASE_W  = 24;
    localparam int DEF_LUT_AW   = 11;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_AMP_W    = 7;
    localparam int GAIN_SH      = 2;

    typedef enum logic [3:0] {
        CLEAR,
        IDLE,
        LATCH,
        RD,
        UPD,
        W1,
        W2,
        MAC,
        SCALE
    } state_t;

endpackage

// File: rtl/harm_phase_ram.sv
// rtl/harm_phase_ram.sv - per-harmonic phase store, single port, write-first, 1-cycle read
module harm_phase_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 24,
    parameter int AW    = 6
) (
    input  logic             fpga_clock,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge fpga_clock) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata_q   <= wdata;
        end else begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/harmonic_engine.sv
// rtl/harmonic_engine.sv - additive harmonic synthesiser: one sample per tick, one harmonic per 5 cycles
module harmonic_engine
    import harmonic_engine_pkg::*;
#(
    parameter int NUM_HARM = DEF_NUM_HARM,
    parameter int PHASE_W  = DEF_PHASE_W,
    parameter int LUT_AW   = DEF_LUT_AW,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int AMP_W    = DEF_AMP_W
) (
    input  logic                       fpga_clock,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic [PHASE_W-1:0]         frequency,
    input  logic [AMP_W-1:0]           decay,
    input  logic [7:0]                 harm_limit,
    input  logic                       odd_only,
    output logic [LUT_AW-1:0]          lut_addr,
    input  logic signed [SAMPLE_W-1:0] lut_data,
    output logic [SAMPLE_W-1:0]        sample_out,
    output logic                       sample_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic                       clip
);

    localparam int HW    = $clog2(NUM_HARM);
    localparam int ACC_W = SAMPLE_W + AMP_W + HW;
    localparam int H_W   = 10;
    localparam int INC_W = PHASE_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    state_t                    state_q, state_d;
    logic [HW:0]               clr_q, clr_d;
    logic [H_W-1:0]            h_q, h_d;
    logic [INC_W-1:0]          inc_q, inc_d;
    logic [INC_W-1:0]          step_q, step_d;
    logic [AMP_W-1:0]          amp_q, amp_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [PHASE_W-1:0]        freq_q, freq_d;
    logic [AMP_W-1:0]          decay_q, decay_d;
    logic [7:0]                limit_q, limit_d;
    logic                      odd_q, odd_d;
    logic [LUT_AW-1:0]         lut_addr_q, lut_addr_d;
    logic [SAMPLE_W-1:0]       sample_out_q, sample_out_d;

    logic                      ram_we;
    logic [HW-1:0]             ram_addr;
    logic [PHASE_W-1:0]        ram_wdata;
    logic [PHASE_W-1:0]        ram_rdata;
    logic [PHASE_W-1:0]        new_phase;
    logic [INC_W:0]            inc_sum;
    logic [H_W-1:0]            h_nxt;
    logic [AMP_W-1:0]          amp_nxt;
    logic                      stop;
    logic signed [SAMPLE_W+AMP_W:0] prod;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [SAMPLE_W-1:0] sat_val;
    logic                      sat_clip;
    logic [SAMPLE_W-1:0]       scaled;

    harm_phase_ram #(
        .DEPTH(NUM_HARM),
        .WIDTH(PHASE_W),
        .AW   (HW)
    ) u_ram (
        .fpga_clock(fpga_clock),
        .we        (ram_we),
        .addr      (ram_addr),
        .wdata     (ram_wdata),
        .rdata     (ram_rdata)
    );

    // One extra bit on the sum keeps the Nyquist test exact even when the first increment is already large
    always_comb begin
        new_phase = ram_rdata + inc_q[PHASE_W-1:0];
        inc_sum   = {1'b0, inc_q} + {1'b0, step_q};
        h_nxt     = h_q + (odd_q ? H_W'(2) : H_W'(1));
        amp_nxt   = (amp_q > decay_q) ? amp_q - decay_q : '0;
        prod      = lut_data * $signed({1'b0, amp_q});
        stop      = (h_nxt > {2'b00, limit_q}) || (h_nxt > H_W'(NUM_HARM)) ||
                    (amp_nxt == '0) || (inc_sum[INC_W:PHASE_W-1] != '0);
    end

    always_comb begin
        shifted  = acc_q >>> (AMP_W + GAIN_SH);
        sat_clip = 1'b0;
        if (shifted > SAT_MAX) begin
            sat_val  = SAT_MAX[SAMPLE_W-1:0];
            sat_clip = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_val  = SAT_MIN[SAMPLE_W-1:0];
            sat_clip = 1'b1;
        end else begin
            sat_val = shifted[SAMPLE_W-1:0];
        end
        scaled = {~sat_val[SAMPLE_W-1], sat_val[SAMPLE_W-2:0]};
    end

    always_comb begin
        state_d      = state_q;
        clr_d        = clr_q;
        h_d          = h_q;
        inc_d        = inc_q;
        step_d       = step_q;
        amp_d        = amp_q;
        acc_d        = acc_q;
        freq_d       = freq_q;
        decay_d      = decay_q;
        limit_d      = limit_q;
        odd_d        = odd_q;
        lut_addr_d   = lut_addr_q;
        sample_out_d = sample_out_q;
        ram_we       = 1'b0;
        ram_addr     = h_q[HW-1:0] - HW'(1);
        ram_wdata    = '0;
        case (state_q)
            CLEAR: begin
                ram_addr = clr_q[HW-1:0];
                if (clr_q == (HW+1)'(NUM_HARM)) begin
                    state_d = IDLE;
                end else begin
                    ram_we = 1'b1;
                    clr_d  = clr_q + (HW+1)'(1);
                end
            end
            IDLE: begin
                if (sample_tick) begin
                    freq_d  = frequency;
                    decay_d = decay;
                    limit_d = harm_limit;
                    odd_d   = odd_only;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                h_d     = H_W'(1);
                inc_d   = {1'b0, freq_q};
                step_d  = odd_q ? {freq_q, 1'b0} : {1'b0, freq_q};
                amp_d   = '1;
                acc_d   = '0;
                state_d = RD;
            end
            RD:  state_d = UPD;
            UPD: begin
                ram_we     = 1'b1;
                ram_wdata  = new_phase;
                lut_addr_d = new_phase[PHASE_W-1 -: LUT_AW];
                state_d    = W1;
            end
            W1:  state_d = W2;
            W2:  state_d = MAC;
            MAC: begin
                acc_d   = acc_q + ACC_W'(prod);
                amp_d   = amp_nxt;
                h_d     = h_nxt;
                inc_d   = inc_sum[INC_W-1:0];
                state_d = stop ? SCALE : RD;
            end
            SCALE: begin
                sample_out_d = scaled;
                state_d      = IDLE;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            state_q      <= CLEAR;
            clr_q        <= '0;
            h_q          <= '0;
            inc_q        <= '0;
            step_q       <= '0;
            amp_q        <= '0;
            acc_q        <= '0;
            freq_q       <= '0;
            decay_q      <= '0;
            limit_q      <= '0;
            odd_q        <= 1'b0;
            lut_addr_q   <= '0;
            sample_out_q <= SAMPLE_W'(1) << (SAMPLE_W - 1);
        end else begin
            state_q      <= state_d;
            clr_q        <= clr_d;
            h_q          <= h_d;
            inc_q        <= inc_d;
            step_q       <= step_d;
            amp_q        <= amp_d;
            acc_q        <= acc_d;
            freq_q       <= freq_d;
            decay_q      <= decay_d;
            limit_q      <= limit_d;
            odd_q        <= odd_d;
            lut_addr_q   <= lut_addr_d;
            sample_out_q <= sample_out_d;
        end
    end

    // The result is presented during SCALE itself so sample_valid lands 2 + 5*K cycles after the tick
    assign busy         = reset || (state_q != IDLE);
    assign overrun      = sample_tick && !reset && (state_q != IDLE);
    assign sample_valid = !reset && (state_q == SCALE);
    assign clip         = sample_valid && sat_clip;
    assign sample_out   = sample_valid ? scaled : sample_out_q;
    assign lut_addr     = lut_addr_q;

endmodule
